// File: rtl/mem_req_arbiter.sv
// Arbitrates ICache refills and DCache refills/stores onto the single SRAM controller port.
// Optional build macro MEM_ARB_PERF_EN adds grant/drop performance counters.
module mem_req_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_drops,
`endif
  input  logic              flush,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_line,
  input  logic              d_valid,
  input  logic              d_store,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_line,
  output logic              mem_req_valid,
  output logic              mem_req_inst,
  output logic              mem_req_store,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_line
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     r_state;
  state_t     w_state_nx;
  logic [3:0] r_starve_cnt;
  logic       r_drop;
  logic       r_grant_i;
  logic       r_cool;
  logic       w_grant_i;
  logic       w_grant_d;
  logic       w_force_i;
  logic       w_resp;
  logic       w_drop_now;

  // Next-state and grant decision
  always_comb begin
    w_state_nx = r_state;
    w_grant_i  = 1'b0;
    w_grant_d  = 1'b0;
    w_resp     = 1'b0;
    w_drop_now = 1'b0;
    w_force_i  = i_valid && !flush && (r_starve_cnt == STARVE_MAX);
    case (r_state)
      ST_IDLE: begin
        // The cycle after a ready pulse is skipped so the requester can drop valid.
        if (!r_cool) begin
          if (d_valid && !w_force_i) begin
            w_grant_d = 1'b1;
          end else if (i_valid && !flush) begin
            w_grant_i = 1'b1;
          end else begin
            w_grant_d = 1'b0;
          end
        end else begin
          w_grant_d = 1'b0;
        end
        if (w_grant_i || w_grant_d) begin
          w_state_nx = ST_BUSY;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_BUSY: begin
        w_drop_now = r_grant_i && (r_drop || flush);
        if (mem_resp_valid) begin
          w_resp     = 1'b1;
          w_state_nx = ST_RESP;
        end else begin
          w_state_nx = ST_BUSY;
        end
      end
      ST_RESP: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Request latch, response capture and ready pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_valid <= 1'b0;
      mem_req_inst  <= 1'b0;
      mem_req_store <= 1'b0;
      mem_req_addr  <= {ADDR_W{1'b0}};
      mem_req_wdata <= {DATA_W{1'b0}};
      r_grant_i     <= 1'b0;
      i_ready       <= 1'b0;
      d_ready       <= 1'b0;
      i_line        <= {LINE_W{1'b0}};
      d_line        <= {LINE_W{1'b0}};
      r_cool        <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      r_cool  <= i_ready | d_ready;
      if (w_grant_i || w_grant_d) begin
        mem_req_valid <= 1'b1;
        mem_req_inst  <= w_grant_i;
        mem_req_store <= w_grant_d & d_store;
        mem_req_addr  <= w_grant_i ? i_addr : d_addr;
        mem_req_wdata <= w_grant_d ? d_wdata : {DATA_W{1'b0}};
        r_grant_i     <= w_grant_i;
      end
      if (w_resp) begin
        mem_req_valid <= 1'b0;
        if (r_grant_i) begin
          if (!w_drop_now) begin
            i_line  <= mem_resp_line;
            i_ready <= 1'b1;
          end
        end else begin
          d_ready <= 1'b1;
          // A store completion is acknowledged by d_ready alone.
          if (!mem_req_store) begin
            d_line <= mem_resp_line;
          end
        end
      end
    end
  end

  // Starvation counter and flush-drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
      r_drop       <= 1'b0;
    end else begin
      if (w_grant_d && i_valid) begin
        if (r_starve_cnt != STARVE_MAX) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end else if (w_grant_i || w_grant_d) begin
        r_starve_cnt <= 4'd0;
      end
      if (r_state == ST_IDLE) begin
        r_drop <= 1'b0;
      end else if (r_state == ST_BUSY && r_grant_i && flush) begin
        r_drop <= 1'b1;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Wrapping performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i_grants <= 32'd0;
      perf_d_grants <= 32'd0;
      perf_drops    <= 32'd0;
    end else begin
      if (w_grant_i) begin
        perf_i_grants <= perf_i_grants + 32'd1;
      end
      if (w_grant_d) begin
        perf_d_grants <= perf_d_grants + 32'd1;
      end
      if (w_resp && w_drop_now) begin
        perf_drops <= perf_drops + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter; inputs change and outputs are sampled on negedge.
module tb_mem_req_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         i_valid;
  logic [31:0]  i_addr;
  logic         i_ready;
  logic [127:0] i_line;
  logic         d_valid;
  logic         d_store;
  logic [31:0]  d_addr;
  logic [31:0]  d_wdata;
  logic         d_ready;
  logic [127:0] d_line;
  logic         mem_req_valid;
  logic         mem_req_inst;
  logic         mem_req_store;
  logic [31:0]  mem_req_addr;
  logic [31:0]  mem_req_wdata;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_line;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]  perf_i_grants;
  logic [31:0]  perf_d_grants;
  logic [31:0]  perf_drops;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] L_I1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] L_D1 = 128'hD1D1_D1D1_0000_0020_AAAA_5555_0F0F_F0F0;
  localparam logic [127:0] L_I2 = 128'h1212_3434_5656_7878_9A9A_BCBC_DEDE_F0F0;
  localparam logic [127:0] L_ST = 128'hBADB_ADBA_DBAD_BADB_ADBA_DBAD_BADB_ADBA;
  localparam logic [127:0] L_SI = 128'h5757_0000_5757_0000_5757_0000_5757_0001;
  localparam logic [127:0] L_FL = 128'hF1F1_F1F1_F1F1_F1F1_F1F1_F1F1_F1F1_F1F1;
  localparam logic [127:0] L_NX = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
  localparam logic [127:0] L_RS = 128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE;

  mem_req_arbiter #(
    .ADDR_W(32), .DATA_W(32), .LINE_W(128), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef MEM_ARB_PERF_EN
    .perf_i_grants(perf_i_grants),
    .perf_d_grants(perf_d_grants),
    .perf_drops(perf_drops),
`endif
    .flush(flush),
    .i_valid(i_valid),
    .i_addr(i_addr),
    .i_ready(i_ready),
    .i_line(i_line),
    .d_valid(d_valid),
    .d_store(d_store),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_ready(d_ready),
    .d_line(d_line),
    .mem_req_valid(mem_req_valid),
    .mem_req_inst(mem_req_inst),
    .mem_req_store(mem_req_store),
    .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_line(mem_resp_line)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model: wait n cycles, then a one-cycle completion pulse.
  task automatic respond(input int n, input logic [127:0] line);
    repeat (n) @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_line  = line;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_line  = 128'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    i_valid = 1'b0; i_addr = 32'h0;
    d_valid = 1'b0; d_store = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    mem_resp_valid = 1'b0; mem_resp_line = 128'h0;
    repeat (2) @(negedge clk);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_i_ready",   i_ready, 1'b0);
    check("rst_d_ready",   d_ready, 1'b0);
    check("rst_req_addr",  mem_req_addr, 32'h0);
    check("rst_i_line",    i_line, 128'h0);
    check("rst_d_line",    d_line, 128'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Lone I refill with a 5-cycle controller
    i_valid = 1'b1; i_addr = 32'h8000_0010;
    @(negedge clk);
    check("i_req_valid", mem_req_valid, 1'b1);
    check("i_req_inst",  mem_req_inst, 1'b1);
    check("i_req_store", mem_req_store, 1'b0);
    check("i_req_addr",  mem_req_addr, 32'h8000_0010);
    repeat (4) @(negedge clk);
    check("i_req_hold", mem_req_valid, 1'b1);
    respond(0, L_I1);
    check("i_ready_pulse", i_ready, 1'b1);
    check("i_line_val",    i_line, L_I1);
    check("i_d_ready_0",   d_ready, 1'b0);
    check("i_req_clear",   mem_req_valid, 1'b0);
    i_valid = 1'b0;
    @(negedge clk);
    check("i_ready_one", i_ready, 1'b0);
    repeat (3) @(negedge clk);

    // Simultaneous I and D: D first, then I after the cooldown cycle
    i_valid = 1'b1; i_addr = 32'h8000_0100;
    d_valid = 1'b1; d_store = 1'b0; d_addr = 32'h8040_0020;
    @(negedge clk);
    check("both_d_first", mem_req_inst, 1'b0);
    check("both_d_store", mem_req_store, 1'b0);
    check("both_d_addr",  mem_req_addr, 32'h8040_0020);
    respond(1, L_D1);
    check("both_d_ready", d_ready, 1'b1);
    check("both_d_line",  d_line, L_D1);
    check("both_i_wait",  i_ready, 1'b0);
    d_valid = 1'b0;
    @(negedge clk);
    check("both_idle", mem_req_valid, 1'b0);
    @(negedge clk);
    check("both_cooldown", mem_req_valid, 1'b0);
    @(negedge clk);
    check("both_i_valid", mem_req_valid, 1'b1);
    check("both_i_inst",  mem_req_inst, 1'b1);
    check("both_i_store", mem_req_store, 1'b0);
    check("both_i_addr",  mem_req_addr, 32'h8000_0100);
    respond(1, L_I2);
    check("both_i_ready", i_ready, 1'b1);
    check("both_i_line",  i_line, L_I2);
    check("both_i_dq",    d_ready, 1'b0);
    i_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Word store: d_line keeps the previous refill
    d_valid = 1'b1; d_store = 1'b1; d_addr = 32'h8040_0004; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("st_store", mem_req_store, 1'b1);
    check("st_inst",  mem_req_inst, 1'b0);
    check("st_addr",  mem_req_addr, 32'h8040_0004);
    check("st_wdata", mem_req_wdata, 32'hDEAD_BEEF);
    respond(2, L_ST);
    check("st_ready",  d_ready, 1'b1);
    check("st_d_line", d_line, L_D1);
    d_valid = 1'b0; d_store = 1'b0;
    @(negedge clk);
    check("st_ready_one", d_ready, 1'b0);
    repeat (3) @(negedge clk);

    // Starvation: exactly 4 D grants, then I is forced
    i_valid = 1'b1; i_addr = 32'h8000_0200;
    d_valid = 1'b1; d_store = 1'b0; d_addr = 32'h8040_0040;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("starve_d_valid", mem_req_valid, 1'b1);
      check("starve_d_inst",  mem_req_inst, 1'b0);
      respond(0, {96'h0, 32'(k)});
      check("starve_d_ready", d_ready, 1'b1);
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    check("starve_i_valid", mem_req_valid, 1'b1);
    check("starve_i_inst",  mem_req_inst, 1'b1);
    check("starve_i_addr",  mem_req_addr, 32'h8000_0200);
    respond(0, L_SI);
    check("starve_i_ready", i_ready, 1'b1);
    check("starve_i_line",  i_line, L_SI);
    i_valid = 1'b0; d_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Flush during BUSY: transaction completes, response dropped
    i_valid = 1'b1; i_addr = 32'h8000_0300;
    @(negedge clk);
    check("fl_inst", mem_req_inst, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; i_valid = 1'b0;
    check("fl_no_abort", mem_req_valid, 1'b1);
    respond(1, L_FL);
    check("fl_no_ready", i_ready, 1'b0);
    check("fl_done",     mem_req_valid, 1'b0);
    check("fl_line_kept", i_line, L_SI);
    @(negedge clk);
    check("fl_no_ready_late", i_ready, 1'b0);
`ifdef MEM_ARB_PERF_EN
    check("perf_drops",    perf_drops, 32'd1);
    check("perf_i_grants", perf_i_grants, 32'd4);
    check("perf_d_grants", perf_d_grants, 32'd6);
`endif
    repeat (2) @(negedge clk);

    // Flush blocks a lone I grant; next request then proceeds normally
    i_valid = 1'b1; i_addr = 32'h8000_0400; flush = 1'b1;
    @(negedge clk);
    check("fl_blocks_i", mem_req_valid, 1'b0);
    flush = 1'b0;
    @(negedge clk);
    check("nx_valid", mem_req_valid, 1'b1);
    check("nx_addr",  mem_req_addr, 32'h8000_0400);
    respond(0, L_NX);
    check("nx_ready", i_ready, 1'b1);
    check("nx_line",  i_line, L_NX);
    i_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-BUSY: late response is ignored
    d_valid = 1'b1; d_store = 1'b0; d_addr = 32'h8040_0080;
    @(negedge clk);
    check("rb_busy", mem_req_valid, 1'b1);
    rst = 1'b1; d_valid = 1'b0;
    @(negedge clk);
    check("rb_valid_0", mem_req_valid, 1'b0);
    check("rb_addr_0",  mem_req_addr, 32'h0);
    rst = 1'b0;
    respond(0, L_RS);
    check("rb_no_d_ready", d_ready, 1'b0);
    check("rb_no_i_ready", i_ready, 1'b0);
    check("rb_idle",       mem_req_valid, 1'b0);
    @(negedge clk);
    check("rb_d_line_0", d_line, 128'h0);
    check("rb_d_ready_0", d_ready, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
